// File: rtl/fib_cmd_sequencer.sv
// fib_cmd_sequencer: command-driven initiator for the Fibonacci generator handshake.
// Accepts one command at a time, drives a single generator job (LOAD then WAIT), and
// queues the outcome (data, order, status) in a small response FIFO.
// Optional feature: define FIB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES cycles
// that clears the generator and reports status 2'b11.
module fib_cmd_sequencer #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned ORDER_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH  = 4
`ifdef FIB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ORDER_WIDTH-1:0] cmd_order,
   input  logic [DATA_WIDTH-1:0]  cmd_start,
   input  logic                   sw_abort,
   output logic                   gen_load,
   output logic                   gen_clear,
   output logic [ORDER_WIDTH-1:0] gen_order,
   output logic [DATA_WIDTH-1:0]  gen_data_in,
   input  logic                   gen_done,
   input  logic                   gen_error,
   input  logic                   gen_overflow,
   input  logic [DATA_WIDTH-1:0]  gen_data_out,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_data,
   output logic [ORDER_WIDTH-1:0] rsp_order,
   output logic [1:0]             rsp_status,
   output logic                   busy
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] StatusOk  = 2'b00;
   localparam logic [1:0] StatusErr = 2'b01;
   localparam logic [1:0] StatusOvf = 2'b10;
   localparam logic [1:0] StatusTmo = 2'b11;

   typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

   state_e                 state_q, state_d;
   logic [ORDER_WIDTH-1:0] order_q;
   logic [DATA_WIDTH-1:0]  start_q;
   logic                   clear_q, clear_d;

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic [DATA_WIDTH-1:0]  push_data;
   logic [1:0]             push_status;
   logic                   timeout_hit;
   logic [CntW-1:0]        occupied;

   logic [DATA_WIDTH-1:0]  mem_data_q   [FIFO_DEPTH];
   logic [ORDER_WIDTH-1:0] mem_order_q  [FIFO_DEPTH];
   logic [1:0]             mem_status_q [FIFO_DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        count_q;

   // The in-flight job holds a reserved FIFO slot, so its completion can always push.
   assign busy      = (state_q != StIdle);
   assign occupied  = count_q + CntW'(busy);
   assign cmd_ready = (state_q == StIdle) && (occupied < CntW'(FIFO_DEPTH));
   assign accept    = cmd_valid && cmd_ready;

   assign gen_load    = (state_q == StLoad);
   assign gen_clear   = clear_q;
   assign gen_order   = order_q;
   assign gen_data_in = start_q;

   assign rsp_valid  = (count_q != '0);
   assign rsp_data   = mem_data_q[rd_ptr_q];
   assign rsp_order  = mem_order_q[rd_ptr_q];
   assign rsp_status = mem_status_q[rd_ptr_q];
   assign pop        = rsp_valid && rsp_ready;

`ifdef FIB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TmoW-1:0] wait_cnt_q;

   // Count WAIT cycles of the current job; zero whenever not waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q <= '0;
      end else if (state_q != StWait) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_q + TmoW'(1);
      end
   end

   // Fires during the last permitted WAIT cycle.
   assign timeout_hit = (state_q == StWait) && (wait_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, clear request and FIFO push decode; completion outranks abort.
   always_comb begin
      state_d     = state_q;
      clear_d     = 1'b0;
      push        = 1'b0;
      push_data   = '0;
      push_status = StatusOk;
      unique case (state_q)
         StIdle: begin
            if (sw_abort) clear_d = 1'b1;
            if (accept)   state_d = StLoad;
         end
         StLoad: begin
            state_d = StWait;
         end
         StWait: begin
            if (gen_error || gen_overflow || gen_done) begin
               push    = 1'b1;
               state_d = StIdle;
               if (gen_error) begin
                  push_status = StatusErr;
               end else if (gen_overflow) begin
                  push_status = StatusOvf;
                  push_data   = gen_data_out;
               end else begin
                  push_data   = gen_data_out;
               end
            end else if (sw_abort) begin
               clear_d = 1'b1;
               state_d = StIdle;
            end else if (timeout_hit) begin
               clear_d     = 1'b1;
               push        = 1'b1;
               push_status = StatusTmo;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control state and the job operands, held stable for the whole job.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         clear_q <= 1'b0;
         order_q <= '0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
         if (accept) begin
            order_q <= cmd_order;
            start_q <= cmd_start;
         end
      end
   end

   // Response FIFO storage, pointers (wrap naturally, depth is a power of two) and count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i]   <= '0;
            mem_order_q[i]  <= '0;
            mem_status_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_data_q[wr_ptr_q]   <= push_data;
            mem_order_q[wr_ptr_q]  <= order_q;
            mem_status_q[wr_ptr_q] <= push_status;
            wr_ptr_q               <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fib_cmd_sequencer.sv
// Self-checking bench for fib_cmd_sequencer. The bench plays the generator, predicts each
// response from the job outcome it chooses, and a monitor checks the response stream.
// Build with FIB_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES = 16).
module tb_fib_cmd_sequencer;

   localparam int DW    = 64;
   localparam int OW    = 16;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   // Job outcomes the bench can stage.
   localparam int KOk        = 0;
   localparam int KErr       = 1;
   localparam int KOvf       = 2;
   localparam int KErrOvf    = 3;
   localparam int KAbort     = 4;
   localparam int KAbortDone = 5;
   localparam int KSilent    = 6;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [OW-1:0] order;
      logic [1:0]    status;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [OW-1:0] cmd_order = '0;
   logic [DW-1:0] cmd_start = '0;
   logic          sw_abort = 1'b0;
   logic          gen_load;
   logic          gen_clear;
   logic [OW-1:0] gen_order;
   logic [DW-1:0] gen_data_in;
   logic          gen_done = 1'b0;
   logic          gen_error = 1'b0;
   logic          gen_overflow = 1'b0;
   logic [DW-1:0] gen_data_out = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic [OW-1:0] rsp_order;
   logic [1:0]    rsp_status;
   logic          busy;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   clear_cnt = 0;
   bit   rand_rdy = 1'b0;

   fib_cmd_sequencer #(
      .DATA_WIDTH (DW),
      .ORDER_WIDTH(OW),
      .FIFO_DEPTH (DEPTH)
`ifdef FIB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_order   (cmd_order),
      .cmd_start   (cmd_start),
      .sw_abort    (sw_abort),
      .gen_load    (gen_load),
      .gen_clear   (gen_clear),
      .gen_order   (gen_order),
      .gen_data_in (gen_data_in),
      .gen_done    (gen_done),
      .gen_error   (gen_error),
      .gen_overflow(gen_overflow),
      .gen_data_out(gen_data_out),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_order   (rsp_order),
      .rsp_status  (rsp_status),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (gen_clear) clear_cnt <= clear_cnt + 1;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
   initial begin
      logic          hold;
      logic [DW-1:0] hd;
      logic [OW-1:0] ho;
      logic [1:0]    hs;
      exp_t          e;
      hold = 1'b0;
      hd = '0;
      ho = '0;
      hs = '0;
      forever begin
         @(negedge clk);
         if (hold) begin
            check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            check("rsp_hold_data", rsp_data, hd);
            check("rsp_hold_order", 64'(rsp_order), 64'(ho));
            check("rsp_hold_status", 64'(rsp_status), 64'(hs));
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL rsp_unexpected: actual=order %0d status %0d required=no response",
                        rsp_order, rsp_status);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_order", 64'(rsp_order), 64'(e.order));
               check("rsp_status", 64'(rsp_status), 64'(e.status));
            end
         end
         hold = rsp_valid && !rsp_ready && reset_n;
         hd = rsp_data;
         ho = rsp_order;
         hs = rsp_status;
      end
   end

   // Issue one command and act as the generator. dly = WAIT cycle (1-based) of the outcome;
   // lnoise bit0 raises gen_done during LOAD, bit1 raises sw_abort during LOAD.
   task automatic issue(input logic [OW-1:0] ord, input logic [DW-1:0] st, input int kind,
                        input int dly, input int lnoise, input logic [DW-1:0] val);
      int   n;
      int   w;
      int   c0;
      int   exp_clr;
      exp_t e;
      cmd_valid = 1'b1;
      cmd_order = ord;
      cmd_start = st;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      if (n == 300) begin
         check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
         step();
         cmd_valid = 1'b0;
         return;
      end
      step();
      cmd_valid = 1'b0;
      c0 = clear_cnt;
      e.order = ord;
      e.data = '0;
      e.status = 2'b00;
      exp_clr = 0;
      case (kind)
         KOk, KAbortDone: begin e.data = val; exp_q.push_back(e); end
         KErr, KErrOvf:   begin e.status = 2'b01; exp_q.push_back(e); end
         KOvf:            begin e.data = val; e.status = 2'b10; exp_q.push_back(e); end
         KSilent:         begin e.status = 2'b11; exp_q.push_back(e); exp_clr = 1; end
         default:         exp_clr = 1;
      endcase
      // LOAD cycle
      @(negedge clk);
      check("load_pulse", 64'(gen_load), 64'd1);
      check("load_order", 64'(gen_order), 64'(ord));
      check("load_start", gen_data_in, st);
      check("load_busy", 64'(busy), 64'd1);
      gen_data_out = val;
      if (lnoise[0]) gen_done = 1'b1;
      if (lnoise[1]) sw_abort = 1'b1;
      step();
      gen_done = 1'b0;
      sw_abort = 1'b0;
      // WAIT cycle 1
      @(negedge clk);
      check("load_single_cycle", 64'(gen_load), 64'd0);
      if (kind == KSilent) begin
         w = 0;
         for (n = 0; n < TMO + 20; n++) begin
            if (!busy) break;
            w++;
            step();
            @(negedge clk);
         end
         check("timeout_wait_cycles", 64'(w), 64'(TMO));
      end else begin
         for (n = 1; n < dly; n++) step();
         check("wait_order_stable", 64'(gen_order), 64'(ord));
         case (kind)
            KOk:        gen_done = 1'b1;
            KErr:       begin gen_error = 1'b1; gen_done = 1'($urandom_range(0, 1)); end
            KOvf:       begin gen_overflow = 1'b1; gen_done = 1'($urandom_range(0, 1)); end
            KErrOvf:    begin gen_error = 1'b1; gen_overflow = 1'b1; end
            KAbort:     sw_abort = 1'b1;
            KAbortDone: begin sw_abort = 1'b1; gen_done = 1'b1; end
            default:    ;
         endcase
         step();
         gen_done = 1'b0;
         gen_error = 1'b0;
         gen_overflow = 1'b0;
         sw_abort = 1'b0;
         @(negedge clk);
         check("idle_after_job", 64'(busy), 64'd0);
      end
      step();
      check("clear_pulses", 64'(clear_cnt - c0), 64'(exp_clr));
   endtask

   // Generator status asserted while no job waits must be ignored.
   task automatic idle_noise();
      gen_done = 1'b1;
      gen_error = 1'($urandom_range(0, 1));
      gen_overflow = 1'($urandom_range(0, 1));
      step();
      gen_done = 1'b0;
      gen_error = 1'b0;
      gen_overflow = 1'b0;
   endtask

   initial begin
      int n;
      int c0;
      int kind;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_gen_load", 64'(gen_load), 64'd0);
      check("reset_gen_clear", 64'(gen_clear), 64'd0);
      check("reset_rsp_data", rsp_data, 64'd0);
      step();

      // Basic job: order 10 -> 55
      issue(16'd10, 64'd0, KOk, 2, 0, 64'd55);

      // Fill the FIFO with the consumer stalled
      rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) issue(16'(i + 1), 64'(i), KOk, 1, 0, 64'(100 + i));
      @(negedge clk);
      check("full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("full_rsp_valid", 64'(rsp_valid), 64'd1);
      step();
      cmd_valid = 1'b1;
      cmd_order = 16'd999;
      repeat (3) begin
         @(negedge clk);
         check("full_no_accept", 64'(busy), 64'd0);
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      @(negedge clk);
      check("one_pop_cmd_ready", 64'(cmd_ready), 64'd1);
      step();
      rsp_ready = 1'b1;
      repeat (6) step();

      // Error, overflow and combined
      issue(16'd7, 64'd3, KErr, 2, 0, 64'hdead_beef);
      issue(16'd100, 64'd1, KOvf, 3, 0, 64'h1234_5678_9abc_def0);
      issue(16'd20, 64'd0, KErrOvf, 1, 0, 64'h77);

      // Abort in WAIT, then a fresh command
      issue(16'd30, 64'd5, KAbort, 3, 0, 64'd0);
      issue(16'd31, 64'd0, KOk, 1, 0, 64'd777);

      // Abort while idle
      sw_abort = 1'b1;
      c0 = clear_cnt;
      step();
      sw_abort = 1'b0;
      @(negedge clk);
      check("idle_abort_clear", 64'(gen_clear), 64'd1);
      check("idle_abort_busy", 64'(busy), 64'd0);
      step();
      check("idle_abort_pulses", 64'(clear_cnt - c0), 64'd1);

      // Abort with completion, abort during LOAD, done during LOAD
      issue(16'd40, 64'd2, KAbortDone, 2, 0, 64'd888);
      issue(16'd41, 64'd1, KOk, 2, 2, 64'd999);
      issue(16'd42, 64'd1, KOk, 2, 1, 64'd5);

`ifdef FIB_TIMEOUT_EN
      issue(16'd50, 64'd0, KSilent, 0, 0, 64'd0);
`else
      issue(16'd50, 64'd0, KAbort, 40, 0, 64'd0);
`endif

      // Randomized jobs with a randomly stalling consumer
      rand_rdy = 1'b1;
      for (int j = 0; j < 60; j++) begin
         kind = $urandom_range(0, 5);
         if ($urandom_range(0, 3) == 0) idle_noise();
         issue(16'($urandom), {$urandom, $urandom}, kind, $urandom_range(1, 5),
               $urandom_range(0, 3), {$urandom, $urandom});
      end
      rand_rdy = 1'b0;
      step();
      rsp_ready = 1'b1;
      for (n = 0; n < 500; n++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      repeat (3) step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a job
      cmd_valid = 1'b1;
      cmd_order = 16'h55;
      cmd_start = 64'd7;
      @(negedge clk);
      check("rst_pre_ready", 64'(cmd_ready), 64'd1);
      step();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_load", 64'(gen_load), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_load_drop", 64'(gen_load), 64'd0);
      check("rst_busy_drop", 64'(busy), 64'd0);
      check("rst_order_drop", 64'(gen_order), 64'd0);
      check("rst_clear_low", 64'(gen_clear), 64'd0);
      step();
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_post_ready", 64'(cmd_ready), 64'd1);
      check("rst_post_rsp_valid", 64'(rsp_valid), 64'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
